// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor: direct-mapped BTB with a 2-bit
// saturating direction counter per entry. Predicts combinationally for
// pc_f_i and is trained by execute-stage resolution.
// Optional statistics counters: define BRANCH_PREDICTOR_STATS_EN.
module branch_predictor #(
  parameter int unsigned INDEX_WIDTH = 6,
  parameter int unsigned XLEN        = 32
) (
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic [XLEN-1:0] pc_f_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            update_en_i,
  input  logic [XLEN-1:0] pc_e_i,
  input  logic            pc_src_res_i,
  input  logic [XLEN-1:0] target_e_i,
  input  logic            pred_taken_e_i,
  input  logic [XLEN-1:0] pred_target_e_i,
  output logic            mispredict_o,
  output logic [31:0]     branch_cnt_o,
  output logic [31:0]     mispredict_cnt_o
);

  localparam int unsigned ENTRIES = 1 << INDEX_WIDTH;
  localparam int unsigned TAG_W   = XLEN - INDEX_WIDTH - 2;

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [XLEN-1:0]    target_d [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];
  logic [1:0]         ctr_d    [ENTRIES];

  logic [INDEX_WIDTH-1:0] idx_f, idx_e;
  logic [TAG_W-1:0]       tag_f, tag_e;
  logic                   hit_f, hit_e;

  // Word-aligned PCs: the two low bits carry no index or tag information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_f_i[1:0], pc_e_i[1:0]};

  assign idx_f = pc_f_i[INDEX_WIDTH+1:2];
  assign tag_f = pc_f_i[XLEN-1:INDEX_WIDTH+2];
  assign idx_e = pc_e_i[INDEX_WIDTH+1:2];
  assign tag_e = pc_e_i[XLEN-1:INDEX_WIDTH+2];

  // Fetch-side lookup: reads pre-edge table contents, no write bypass.
  always_comb begin
    hit_f         = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    pred_taken_o  = hit_f && ctr_q[idx_f][1];
    pred_target_o = pred_taken_o ? target_q[idx_f] : '0;
  end

  // Mispredict: wrong direction, or taken with a wrong target.
  always_comb begin
    mispredict_o = update_en_i &&
                   ((pred_taken_e_i != pc_src_res_i) ||
                    (pc_src_res_i && (pred_target_e_i != target_e_i)));
  end

  // Training: saturating counter on hit, allocate only on taken miss.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    hit_e    = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    if (update_en_i) begin
      if (hit_e) begin
        if (pc_src_res_i) begin
          target_d[idx_e] = target_e_i;
          if (ctr_q[idx_e] != 2'b11) ctr_d[idx_e] = ctr_q[idx_e] + 2'b01;
        end else begin
          if (ctr_q[idx_e] != 2'b00) ctr_d[idx_e] = ctr_q[idx_e] - 2'b01;
        end
      end else if (pc_src_res_i) begin
        valid_d[idx_e]  = 1'b1;
        tag_d[idx_e]    = tag_e;
        target_d[idx_e] = target_e_i;
        ctr_d[idx_e]    = 2'b10;
      end
    end
  end

  // Table state register; reset leaves every entry invalid, weakly not-taken.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

  // Statistics next-state: both counters wrap naturally at 32 bits.
  always_comb begin
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (update_en_i)  branch_cnt_d     = branch_cnt_q + 32'd1;
    if (mispredict_o) mispredict_cnt_d = mispredict_cnt_q + 32'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;
`else
  assign branch_cnt_o     = '0;
  assign mispredict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (INDEX_WIDTH=6, XLEN=32).
// Honours BRANCH_PREDICTOR_STATS_EN for the statistics expectations.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] pc_f;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        update_en;
  logic [31:0] pc_e;
  logic        pc_src_res;
  logic [31:0] target_e;
  logic        pred_taken_e;
  logic [31:0] pred_target_e;
  logic        mispredict;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_br = 0;
  int unsigned exp_mc = 0;

  branch_predictor #(.INDEX_WIDTH(6), .XLEN(32)) dut (
    .clk_i            (clk),
    .reset_n_i        (reset_n),
    .pc_f_i           (pc_f),
    .pred_taken_o     (pred_taken),
    .pred_target_o    (pred_target),
    .update_en_i      (update_en),
    .pc_e_i           (pc_e),
    .pc_src_res_i     (pc_src_res),
    .target_e_i       (target_e),
    .pred_taken_e_i   (pred_taken_e),
    .pred_target_e_i  (pred_target_e),
    .mispredict_o     (mispredict),
    .branch_cnt_o     (branch_cnt),
    .mispredict_cnt_o (mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic predict(input string tag, input logic [31:0] pc,
                         input logic exp_t, input logic [31:0] exp_tgt);
    @(negedge clk);
    pc_f = pc;
    #1;
    check({tag, " taken"}, {31'd0, pred_taken}, {31'd0, exp_t});
    check({tag, " target"}, pred_target, exp_tgt);
  endtask

  task automatic do_update(input string tag, input logic [31:0] pc, input logic taken,
                           input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt,
                           input logic exp_mis);
    @(negedge clk);
    update_en     = 1'b1;
    pc_e          = pc;
    pc_src_res    = taken;
    target_e      = tgt;
    pred_taken_e  = pt;
    pred_target_e = ptgt;
    #1;
    check({tag, " mispredict"}, {31'd0, mispredict}, {31'd0, exp_mis});
    exp_br++;
    if (exp_mis) exp_mc++;
    @(posedge clk);
    #1;
    update_en = 1'b0;
  endtask

  task automatic check_stats(input string tag);
`ifdef BRANCH_PREDICTOR_STATS_EN
    check({tag, " branch_cnt"}, branch_cnt, exp_br);
    check({tag, " mispredict_cnt"}, mispredict_cnt, exp_mc);
`else
    check({tag, " branch_cnt"}, branch_cnt, 32'd0);
    check({tag, " mispredict_cnt"}, mispredict_cnt, 32'd0);
`endif
  endtask

  initial begin
    reset_n       = 1'b0;
    pc_f          = '0;
    update_en     = 1'b0;
    pc_e          = 32'h40;
    pc_src_res    = 1'b1;
    target_e      = 32'h100;
    pred_taken_e  = 1'b0;
    pred_target_e = '0;
    #12;
    check("reset taken", {31'd0, pred_taken}, 32'd0);
    check("reset target", pred_target, 32'd0);
    check("reset mispredict", {31'd0, mispredict}, 32'd0);
    check_stats("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // 1: empty table, disabled-update junk on the execute inputs must not train
    for (int i = 0; i < 64; i++) predict("sweep", 32'(i * 4), 1'b0, 32'h0);
    check("idle mispredict", {31'd0, mispredict}, 32'd0);

    // 2: cold taken branch allocates
    do_update("cold", 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    predict("cold hit", 32'h40, 1'b1, 32'h100);
    predict("cold other idx", 32'h44, 1'b0, 32'h0);

    // 3: counter 10->01->00->00 then 01->10
    do_update("nt1", 32'h40, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1);
    predict("after nt1", 32'h40, 1'b0, 32'h0);
    do_update("nt2", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    do_update("nt3", 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    predict("after nt3", 32'h40, 1'b0, 32'h0);
    do_update("t1", 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    predict("after t1", 32'h40, 1'b0, 32'h0);
    do_update("t2", 32'h40, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
    predict("after t2", 32'h40, 1'b1, 32'h100);

    // 4: alias at 0x140 shares index with 0x40
    do_update("alias nt", 32'h140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    predict("alias kept", 32'h40, 1'b1, 32'h100);
    predict("alias miss", 32'h140, 1'b0, 32'h0);
    do_update("alias t", 32'h140, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
    predict("evicted", 32'h40, 1'b0, 32'h0);
    predict("alias hit", 32'h140, 1'b1, 32'h200);

    // 5: same-cycle predict and update at 0x80
    @(negedge clk);
    pc_f          = 32'h80;
    update_en     = 1'b1;
    pc_e          = 32'h80;
    pc_src_res    = 1'b1;
    target_e      = 32'h300;
    pred_taken_e  = 1'b0;
    pred_target_e = 32'h0;
    #1;
    check("same-cycle taken", {31'd0, pred_taken}, 32'd0);
    check("same-cycle mispredict", {31'd0, mispredict}, 32'd1);
    exp_br++;
    exp_mc++;
    @(posedge clk);
    #1;
    update_en = 1'b0;
    check("next-cycle taken", {31'd0, pred_taken}, 32'd1);
    check("next-cycle target", pred_target, 32'h300);
    check_stats("pre-reset");

    // asynchronous reset in the middle of the low phase
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset taken", {31'd0, pred_taken}, 32'd0);
    check("midreset target", pred_target, 32'd0);
    exp_br = 0;
    exp_mc = 0;
    check_stats("midreset");
    @(negedge clk);
    reset_n = 1'b1;
    predict("post-reset alias", 32'h140, 1'b0, 32'h0);

    // 6: target mismatch and upper saturation
    do_update("tgt mismatch", 32'h40, 1'b1, 32'h180, 1'b1, 32'h100, 1'b1);
    do_update("tgt match", 32'h40, 1'b1, 32'h180, 1'b1, 32'h180, 1'b0);
    do_update("sat high", 32'h40, 1'b1, 32'h180, 1'b1, 32'h180, 1'b0);
    do_update("nt from 11", 32'h40, 1'b0, 32'h444, 1'b1, 32'h180, 1'b1);
    predict("still taken", 32'h40, 1'b1, 32'h180);
    do_update("nt tgt ignored", 32'h40, 1'b0, 32'h20, 1'b0, 32'h10, 1'b0);
    predict("now not taken", 32'h40, 1'b0, 32'h0);
    check_stats("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
